move_arbiter: RTL

MOVE_ARBITER -- requirements
Module: move_arbiter

---
 rtl/connect4_pkg.sv | 22 ++
 rtl/move_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry defaults, cell encoding and
// the move-arbiter FSM state encoding.
package connect4_pkg;

  localparam int unsigned ROWS_DEF = 6;
  localparam int unsigned COLS_DEF = 7;

  // Two-bit board cell contents.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SCAN   = 2'b01,
    WRITE  = 2'b10,
    REJECT = 2'b11
  } state_e;

endpackage

// File: rtl/move_arbiter.sv
// move_arbiter: accepts a move from the player on turn (or a random timeout
// move), scans the chosen column bottom-up for the first empty cell, and
// writes the player's token there.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   current_player           0 = FPGA, 1 = Arduino
//   req_fpga/col_fpga        FPGA move request and column
//   req_ard/col_ard          Arduino move request and column
//   time_out/rand_col        turn timer expiry and random column
//   game_over                blocks acceptance of new moves
//   rd_row/rd_col/rd_data    board read port (rd_data combinational)
//   wr_en/wr_row/wr_col/wr_data  board cell write
//   busy/move_done/move_invalid  status and result pulses
//
// Build option: CONNECT4_RANDOM_MOVE_EN enables timeout moves with column
// advance; without it time_out and rand_col are ignored.
module move_arbiter
  import connect4_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       current_player,
  input  logic       req_fpga,
  input  logic [2:0] col_fpga,
  input  logic       req_ard,
  input  logic [2:0] col_ard,
  input  logic       time_out,
  input  logic [2:0] rand_col,
  input  logic       game_over,
  output logic [2:0] rd_row,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_data,
  output logic       wr_en,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_data,
  output logic       busy,
  output logic       move_done,
  output logic       move_invalid
);

  localparam int unsigned RW = 3;
  localparam int unsigned CW = 3;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic            player_q, player_d;
  logic            accept;
  logic [CW-1:0]   acc_col;

`ifdef CONNECT4_RANDOM_MOVE_EN
  logic            timeout_q, timeout_d;
  logic [CW-1:0]   tries_q, tries_d;
`else
  logic            unused_rand;
  assign unused_rand = ^{time_out, rand_col};
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      player_q <= 1'b0;
`ifdef CONNECT4_RANDOM_MOVE_EN
      timeout_q <= 1'b0;
      tries_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      player_q <= player_d;
`ifdef CONNECT4_RANDOM_MOVE_EN
      timeout_q <= timeout_d;
      tries_q   <= tries_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    player_d = player_q;
    accept   = 1'b0;
    acc_col  = '0;
`ifdef CONNECT4_RANDOM_MOVE_EN
    timeout_d = timeout_q;
    tries_d   = tries_q;
`endif
    case (state_q)
      IDLE: begin
        if (!game_over) begin
`ifdef CONNECT4_RANDOM_MOVE_EN
          timeout_d = 1'b0;
          if (time_out) begin
            accept    = 1'b1;
            acc_col   = rand_col;
            timeout_d = 1'b1;
          end else
`endif
          if (!current_player && req_fpga) begin
            accept  = 1'b1;
            acc_col = col_fpga;
          end else if (current_player && req_ard) begin
            accept  = 1'b1;
            acc_col = col_ard;
          end
        end
        if (accept) begin
          row_d    = '0;
          col_d    = acc_col;
          player_d = current_player;
`ifdef CONNECT4_RANDOM_MOVE_EN
          tries_d  = '0;
`endif
          state_d  = (32'(acc_col) >= COLS) ? REJECT : SCAN;
        end
      end
      SCAN: begin
        if (row_q == RW'(ROWS)) begin
          // Column full: player moves fail, timeout moves try the next column.
          state_d = REJECT;
`ifdef CONNECT4_RANDOM_MOVE_EN
          if (timeout_q && (tries_q != CW'(COLS - 1))) begin
            state_d = SCAN;
            row_d   = '0;
            tries_d = tries_q + CW'(1);
            col_d   = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
          end
`endif
        end else if (rd_data == EMPTY) begin
          state_d = WRITE;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      WRITE:   state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from registered state.
  always_comb begin
    busy         = (state_q != IDLE);
    rd_row       = '0;
    rd_col       = '0;
    wr_en        = 1'b0;
    wr_row       = '0;
    wr_col       = '0;
    wr_data      = EMPTY;
    move_done    = 1'b0;
    move_invalid = 1'b0;
    case (state_q)
      SCAN: begin
        rd_row = row_q;
        rd_col = col_q;
      end
      WRITE: begin
        wr_en     = 1'b1;
        move_done = 1'b1;
        wr_row    = row_q;
        wr_col    = col_q;
        wr_data   = player_q ? P2 : P1;
      end
      REJECT:  move_invalid = 1'b1;
      default: ;
    endcase
  end

endmodule
